// File: rtl/nec_bus_pkg.sv
// Shared types and constants for the NEC V30 bus slave.
//   bus_state_e : bus-cycle FSM states
//   bus_op_t    : one captured CPU bus operation as presented to the backend
//   INTA_DATA   : vector returned on interrupt-acknowledge cycles
//   TIMEOUT_DATA: read data returned when the backend never answers
package nec_bus_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } bus_state_e;

  typedef struct packed {
    logic [19:0] addr;
    logic [1:0]  be;
    logic        write;
    logic        io;
    logic [15:0] wdata;
  } bus_op_t;

  localparam logic [15:0] INTA_DATA    = 16'h0000;
  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

  // Raw inputs bundled through the synchroniser: 20 AD bits plus six strobes.
  localparam int unsigned SyncWidth = 26;

  // Byte enables in active-high form: {upper byte, lower byte}.
  function automatic logic [1:0] calc_be(input logic ubenn, input logic a0);
    return {~ubenn, ~a0};
  endfunction

endpackage

// File: rtl/nec_sync.sv
// Multi-flop synchroniser for a bus of asynchronous inputs.
// All bits share the same depth so that data stays aligned with its strobes.
//   clk, reset : system clock, synchronous active-high reset
//   d          : raw asynchronous inputs
//   q          : inputs delayed by Stages flops
module nec_sync #(
  parameter int unsigned       Width    = 1,
  parameter int unsigned       Stages   = 2,
  parameter logic [Width-1:0]  ResetVal = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  logic [Width-1:0] sync_q [Stages];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(Stages); i++) begin
        sync_q[i] <= ResetVal;
      end
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < int'(Stages); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q = sync_q[Stages-1];

endmodule

// File: rtl/nec_bus_slave.sv
// NEC V30 bus slave: turns each CPU memory/IO read or write cycle into one
// valid/ready request to a backend and holds the CPU in wait states (READY low)
// until the backend responds, then returns read data on AD.
//   clk, reset            : system clock, synchronous active-high reset
//   nec_ad_in, nec_*      : raw CPU pins (AD, ASTB, RDn, WRn, IOn, UBEn, INTAKn)
//   nec_ready             : CPU READY, low unless a cycle is being completed
//   nec_ad_out, nec_ad_oe : read data and output enable for AD[15:0]
//   req_*                 : backend request channel (valid/ready)
//   rsp_valid, rsp_rdata  : backend completion and read data
//   timeout_err, proto_err: single-cycle error pulses
module nec_bus_slave
  import nec_bus_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] nec_ad_in,
  input  logic        nec_astb,
  input  logic        nec_rdn,
  input  logic        nec_wrn,
  input  logic        nec_ion,
  input  logic        nec_ubenn,
  input  logic        nec_intakn,
  output logic        nec_ready,
  output logic [15:0] nec_ad_out,
  output logic        nec_ad_oe,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_write,
  output logic        req_io,
  output logic [19:0] req_addr,
  output logic [1:0]  req_be,
  output logic [15:0] req_wdata,
  input  logic        rsp_valid,
  input  logic [15:0] rsp_rdata,
  output logic        timeout_err,
  output logic        proto_err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  // Strobes reset to their inactive level so reset never looks like a bus cycle.
  localparam logic [SyncWidth-1:0] SyncRst = {5'b11111, 1'b0, 20'h00000};

  logic [SyncWidth-1:0] sync_out;
  logic [19:0] s_ad;
  logic        s_astb, s_rdn, s_wrn, s_ion, s_ubenn, s_intakn;

  nec_sync #(
    .Width    (SyncWidth),
    .Stages   (SYNC_STAGES),
    .ResetVal (SyncRst)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     ({nec_intakn, nec_ubenn, nec_ion, nec_wrn, nec_rdn, nec_astb, nec_ad_in}),
    .q     (sync_out)
  );

  assign {s_intakn, s_ubenn, s_ion, s_wrn, s_rdn, s_astb, s_ad} = sync_out;

  // Address phase latch: transparent while ASTB is high, frozen otherwise.
  logic [19:0] addr_q;
  logic        ubenn_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      ubenn_q <= 1'b0;
    end else if (s_astb) begin
      addr_q  <= s_ad;
      ubenn_q <= s_ubenn;
    end
  end

  bus_state_e        state_q, state_d;
  bus_op_t           op_q, op_d;
  logic [15:0]       rdata_q, rdata_d;
  logic              inta_q, inta_d;
  logic [CntW-1:0]   cnt_q, cnt_d, cnt_inc;
  logic              tmo_q, tmo_d;
  logic              proto_q, proto_d;
  logic              strobe_released;

  assign cnt_inc = cnt_q + CntW'(1);

  // The strobe that opened the cycle is the one whose release closes it.
  assign strobe_released = inta_q ? s_intakn : (op_q.write ? s_wrn : s_rdn);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rdata_d = rdata_q;
    inta_d  = inta_q;
    cnt_d   = cnt_q;
    tmo_d   = 1'b0;
    proto_d = 1'b0;

    case (state_q)
      StIdle: begin
        if (!s_rdn || !s_wrn) begin
          state_d     = StReq;
          inta_d      = 1'b0;
          op_d.addr   = addr_q;
          op_d.be     = calc_be(ubenn_q, addr_q[0]);
          // A simultaneous RD/WR is served as a read.
          op_d.write  = !s_wrn && s_rdn;
          op_d.io     = !s_ion;
          op_d.wdata  = s_ad[15:0];
          proto_d     = !s_rdn && !s_wrn;
        end else if (!s_intakn) begin
          state_d = StDone;
          inta_d  = 1'b1;
          rdata_d = INTA_DATA;
        end
      end

      StReq: begin
        if (req_ready) begin
          state_d = StWait;
          cnt_d   = '0;
        end
      end

      StWait: begin
        if (rsp_valid) begin
          state_d = StDone;
          if (!op_q.write) begin
            rdata_d = rsp_rdata;
          end
        end else if (cnt_inc == CntW'(TIMEOUT)) begin
          state_d = StDone;
          rdata_d = TIMEOUT_DATA;
          tmo_d   = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      StDone: begin
        if (strobe_released) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= '0;
      rdata_q <= '0;
      inta_q  <= 1'b0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
      proto_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rdata_q <= rdata_d;
      inta_q  <= inta_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      proto_q <= proto_d;
    end
  end

  assign req_valid   = (state_q == StReq);
  assign req_write   = op_q.write;
  assign req_io      = op_q.io;
  assign req_addr    = op_q.addr;
  assign req_be      = op_q.be;
  assign req_wdata   = op_q.wdata;

  assign nec_ready   = (state_q == StDone);
  assign nec_ad_oe   = (state_q == StDone) && (inta_q || !op_q.write);
  assign nec_ad_out  = rdata_q;

  assign timeout_err = tmo_q;
  assign proto_err   = proto_q;

endmodule

// File: tb/tb_nec_bus_slave.sv
// Self-checking bench for nec_bus_slave: table of bus cycles plus hand-written
// timeout, reset, protocol-error and interrupt-acknowledge sequences.
module tb_nec_bus_slave;

  localparam int unsigned Timeout = 1023;

  logic        clk;
  logic        reset;
  logic [19:0] nec_ad_in;
  logic        nec_astb, nec_rdn, nec_wrn, nec_ion, nec_ubenn, nec_intakn;
  logic        nec_ready;
  logic [15:0] nec_ad_out;
  logic        nec_ad_oe;
  logic        req_valid, req_ready, req_write, req_io;
  logic [19:0] req_addr;
  logic [1:0]  req_be;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        timeout_err, proto_err;

  nec_bus_slave #(
    .SYNC_STAGES (2),
    .TIMEOUT     (Timeout)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nec_ad_in   (nec_ad_in),
    .nec_astb    (nec_astb),
    .nec_rdn     (nec_rdn),
    .nec_wrn     (nec_wrn),
    .nec_ion     (nec_ion),
    .nec_ubenn   (nec_ubenn),
    .nec_intakn  (nec_intakn),
    .nec_ready   (nec_ready),
    .nec_ad_out  (nec_ad_out),
    .nec_ad_oe   (nec_ad_oe),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_io      (req_io),
    .req_addr    (req_addr),
    .req_be      (req_be),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .timeout_err (timeout_err),
    .proto_err   (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        io;
    logic [19:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
  } exp_req_t;

  typedef struct {
    logic        oe;
    logic [15:0] data;
  } exp_rsp_t;

  typedef struct {
    logic        wr;
    logic        io;
    logic [19:0] addr;
    logic        ubenn;
    logic [15:0] wdata;
    logic [15:0] rdata;
    int          dly;
    logic [1:0]  be;
  } vec_t;

  exp_req_t req_sb[$];
  exp_rsp_t rsp_sb[$];
  exp_req_t mon_req;
  exp_rsp_t mon_rsp;
  vec_t     vecs[5];

  int   checks = 0;
  int   failures = 0;
  int   proto_cnt = 0;
  int   tmo_cnt = 0;
  logic ready_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumers: requests at handshake, responses at READY rise.
  always @(negedge clk) begin
    if (proto_err) proto_cnt++;
    if (timeout_err) tmo_cnt++;
    if (req_valid && req_ready) begin
      if (req_sb.size() == 0) begin
        chk("req_valid_unexpected", 64'(req_valid), 64'd0);
      end else begin
        mon_req = req_sb.pop_front();
        chk("req_fields", {req_write, req_io, req_addr, req_be},
            {mon_req.wr, mon_req.io, mon_req.addr, mon_req.be});
        if (mon_req.wr) chk("req_wdata", 64'(req_wdata), 64'(mon_req.wdata));
      end
    end
    if (nec_ready && !ready_prev) begin
      if (rsp_sb.size() == 0) begin
        chk("ready_unexpected", 64'(nec_ready), 64'd0);
      end else begin
        mon_rsp = rsp_sb.pop_front();
        chk("rsp_oe", 64'(nec_ad_oe), 64'(mon_rsp.oe));
        if (mon_rsp.oe) chk("rsp_data", 64'(nec_ad_out), 64'(mon_rsp.data));
      end
    end
    ready_prev = nec_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_ctl"}, {nec_ready, nec_ad_oe, req_valid}, 64'd0);
    chk({tag, "_ad_out"}, 64'(nec_ad_out), 64'd0);
    chk({tag, "_req"}, {req_write, req_io, req_addr, req_be, req_wdata}, 64'd0);
    chk({tag, "_err"}, {timeout_err, proto_err}, 64'd0);
  endtask

  task automatic start_cycle(input logic rd_low, input logic wr_low, input logic io,
                             input logic [19:0] addr, input logic ubenn,
                             input logic [15:0] wdata, input logic [1:0] exp_be,
                             input logic exp_wr);
    exp_req_t e;
    int lat;
    tick();
    nec_astb  = 1'b1;
    nec_ad_in = addr;
    nec_ubenn = ubenn;
    nec_ion   = ~io;
    tick();
    tick();
    nec_astb  = 1'b0;
    nec_ad_in = {4'h0, wdata};
    tick();
    nec_rdn = ~rd_low;
    nec_wrn = ~wr_low;
    e.wr = exp_wr; e.io = io; e.addr = addr; e.be = exp_be; e.wdata = wdata;
    req_sb.push_back(e);
    lat = 0;
    while (!req_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    // Two sync flops, then one registered FSM step.
    chk("req_latency", 64'(lat), 64'd4);
  endtask

  task automatic accept(input int dly, input logic [19:0] addr);
    bit stable;
    stable = 1'b1;
    for (int i = 0; i < dly; i++) begin
      tick();
      rsp_valid = (i == 1);
      rsp_rdata = 16'hDEAD;
      @(negedge clk);
      if (!req_valid || req_addr !== addr || nec_ready) stable = 1'b0;
    end
    if (dly > 0) chk("req_hold", 64'(stable), 64'd1);
    tick();
    rsp_valid = 1'b0;
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
  endtask

  task automatic respond(input logic exp_oe, input logic [15:0] data);
    exp_rsp_t r;
    tick();
    tick();
    r.oe = exp_oe; r.data = data;
    rsp_sb.push_back(r);
    rsp_valid = 1'b1;
    rsp_rdata = data;
    tick();
    rsp_valid = 1'b0;
    rsp_rdata = 16'h0000;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!nec_ready && n < int'(Timeout) + 20) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", 64'(nec_ready), 64'd1);
  endtask

  task automatic end_cycle();
    tick();
    nec_rdn    = 1'b1;
    nec_wrn    = 1'b1;
    nec_intakn = 1'b1;
    repeat (3) @(negedge clk);
    chk("ready_hold", 64'(nec_ready), 64'd1);
    @(negedge clk);
    chk("ready_drop", {nec_ready, nec_ad_oe}, 64'd0);
    repeat (2) tick();
  endtask

  task automatic run_vec(input vec_t v);
    start_cycle(!v.wr, v.wr, v.io, v.addr, v.ubenn, v.wdata, v.be, v.wr);
    accept(v.dly, v.addr);
    respond(!v.wr, v.rdata);
    wait_ready();
    end_cycle();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int p0;
    bit saw_req;

    //           wr    io    addr      ubenn wdata     rdata     dly be
    vecs[0] = '{1'b0, 1'b0, 20'h12345, 1'b0, 16'h0000, 16'hBEEF, 0,  2'b10};
    vecs[1] = '{1'b1, 1'b1, 20'h00080, 1'b1, 16'h00A5, 16'h0000, 1,  2'b01};
    vecs[2] = '{1'b0, 1'b0, 20'h0FFFE, 1'b0, 16'h0000, 16'h1234, 10, 2'b11};
    vecs[3] = '{1'b0, 1'b1, 20'h00003, 1'b1, 16'h0000, 16'h5A5A, 2,  2'b00};
    vecs[4] = '{1'b1, 1'b0, 20'hABCDE, 1'b1, 16'hC3C3, 16'h0000, 3,  2'b01};

    reset      = 1'b1;
    nec_ad_in  = '0;
    nec_astb   = 1'b0;
    nec_rdn    = 1'b1;
    nec_wrn    = 1'b1;
    nec_ion    = 1'b1;
    nec_ubenn  = 1'b1;
    nec_intakn = 1'b1;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    rsp_rdata  = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("rst");
    tick();
    reset = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);
    chk("no_err_pulses", 64'(proto_cnt + tmo_cnt), 64'd0);

    // Backend never answers a read: forced completion with all-ones data.
    start_cycle(1'b1, 1'b0, 1'b0, 20'h00100, 1'b1, 16'h0000, 2'b01, 1'b0);
    accept(0, 20'h00100);
    mon_rsp.oe = 1'b1;
    mon_rsp.data = 16'hFFFF;
    rsp_sb.push_back(mon_rsp);
    n = 0;
    while (!timeout_err && n < int'(Timeout) + 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_window", 64'(n >= int'(Timeout) - 1 && n <= int'(Timeout) + 2), 64'd1);
    @(negedge clk);
    chk("tmo_single_pulse", 64'(tmo_cnt), 64'd1);
    chk("tmo_ad_out", 64'(nec_ad_out), 64'hFFFF);
    wait_ready();
    end_cycle();

    // Reset while waiting on the backend; the late response must be dropped.
    start_cycle(1'b1, 1'b0, 1'b0, 20'h00200, 1'b0, 16'h0000, 2'b11, 1'b0);
    accept(0, 20'h00200);
    tick();
    reset   = 1'b1;
    nec_rdn = 1'b1;
    tick();
    @(negedge clk);
    check_reset_values("midrst");
    tick();
    reset = 1'b0;
    tick();
    rsp_valid = 1'b1;
    rsp_rdata = 16'h7777;
    tick();
    rsp_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst_rsp_ignored", {nec_ready, nec_ad_oe, req_valid}, 64'd0);
    run_vec(vecs[0]);

    // RD and WR asserted together: served as a read, flagged once.
    p0 = proto_cnt;
    start_cycle(1'b1, 1'b1, 1'b0, 20'h0A0A1, 1'b0, 16'h5555, 2'b10, 1'b0);
    accept(0, 20'h0A0A1);
    respond(1'b1, 16'h4242);
    wait_ready();
    end_cycle();
    chk("proto_pulse", 64'(proto_cnt - p0), 64'd1);

    // Interrupt acknowledge: no backend request, zero vector driven.
    tick();
    nec_ad_in  = 20'h0BEEF;
    nec_intakn = 1'b0;
    mon_rsp.oe = 1'b1;
    mon_rsp.data = 16'h0000;
    rsp_sb.push_back(mon_rsp);
    n = 0;
    saw_req = 1'b0;
    while (!nec_ready && n < 20) begin
      @(negedge clk);
      n++;
      if (req_valid) saw_req = 1'b1;
    end
    chk("inta_no_req", 64'(saw_req), 64'd0);
    chk("inta_ready", {nec_ready, nec_ad_oe}, 64'd3);
    chk("inta_ad_out", 64'(nec_ad_out), 64'd0);
    end_cycle();

    chk("sb_drained", 64'(req_sb.size() + rsp_sb.size()), 64'd0);
    chk("err_totals", {32'(proto_cnt), 32'(tmo_cnt)}, {32'd1, 32'd1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
